reg_file_wb: RTL

Writeback stage and architectural register file for the 5-stage MIPS32 pipeline. Consumes the MEM/WB pipeline register outputs and selects the writeback value (ALU result, load data or link PC). Commits that value into a 32 x 32-bit register file with `$zero` hardwired. Serves the two decode-stage read ports, with same-cycle write-to-read bypass.

---
 rtl/reg_file_wb.sv | 73 +++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Writeback source select plus the 32 x WIDTH architectural register file.
// $zero is hardwired, and same-cycle commits can be forwarded to both read ports.
module reg_file_wb #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_reg_ctl_in,
  input  logic [1:0]       mem_to_reg_in,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic [WIDTH-1:0] pc_value_in,
  input  logic [4:0]       w_reg_addr_in,
  input  logic [4:0]       r_addr_1_in,
  input  logic [4:0]       r_addr_2_in,
  output logic [WIDTH-1:0] r_data_1_out,
  output logic [WIDTH-1:0] r_data_2_out,
  output logic [WIDTH-1:0] wb_data_out,
  output logic [31:0]      wb_count_out
);

  logic [WIDTH-1:0] regs [1:31];
  logic [31:0]      wb_count_q;
  logic             commit;

  always_comb begin
    case (mem_to_reg_in)
      2'b01:   wb_data_out = mem_data_in;
      2'b10:   wb_data_out = pc_value_in;
      default: wb_data_out = alu_result_in;
    endcase
  end

  assign commit = w_reg_ctl_in && (w_reg_addr_in != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[w_reg_addr_in] <= wb_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q <= '0;
    end else if (commit) begin
      wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign wb_count_out = wb_count_q;

  // Address 0 is tested first so neither storage nor bypass can leak a value out of $zero.
  function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end else if ((BYPASS != 0) && commit && (addr == w_reg_addr_in)) begin
      return wb_data_out;
    end else begin
      return regs[addr];
    end
  endfunction

  always_comb begin
    r_data_1_out = read_port(r_addr_1_in);
    r_data_2_out = read_port(r_addr_2_in);
  end

endmodule
